vga_grid_reader: RTL and testbench

//  Read-side consumer of the cell register bank. Generates VGA 640x480 timing and scans the bank cell-by-cell.
//  - Drives the bank's 4-bit read address; the bank returns its 3-bit datum combinationally in the same clk.
//  - Renders a 4x4 grid of cells to RGB111. Sits between the register bank and the VGA connector pins.

---
 rtl/vga_timing_pkg.sv | 45 ++++
 rtl/vga_timing_gen.sv | 90 +++++++++
 rtl/vga_grid_reader.sv | 196 +++++++++++++++++++
 tb/tb_vga_grid_reader.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Shared 640x480@60 timing constants, colour constants and
//                the S1 pipeline record used by the VGA grid reader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [2:0] RGB_BLACK = 3'b000;
    localparam logic [2:0] RGB_WHITE = 3'b111;

    // Per-pixel attributes carried alongside the bank read address
    typedef struct packed {
        logic active;     // pixel lies inside the visible area
        logic cell_edge;  // first column or first line of a cell
        logic hsync_n;    // horizontal sync level for this pixel
        logic vsync_n;    // vertical sync level for this pixel
        logic first;      // pixel (0,0) of the frame
    } s1_t;

    localparam s1_t S1_IDLE = '{active: 1'b0, cell_edge: 1'b0,
                                hsync_n: 1'b1, vsync_n: 1'b1, first: 1'b0};

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Horizontal/vertical scan counters advancing on pix_ce, with
//                wrap strobes, visible-area flags and active-low sync terms.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen #(
    parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK,
    parameter int HW        = vga_timing_pkg::cnt_width(H_VISIBLE + H_FRONT + H_SYNC + H_BACK),
    parameter int VW        = vga_timing_pkg::cnt_width(V_VISIBLE + V_FRONT + V_SYNC + V_BACK)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_ce,
    output logic [HW-1:0] h_cnt_o,
    output logic [VW-1:0] v_cnt_o,
    output logic          h_wrap_o,
    output logic          v_wrap_o,
    output logic          h_act_o,
    output logic          v_act_o,
    output logic          hsync_n_o,
    output logic          vsync_n_o
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [HW-1:0] C_H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] C_H_VIS    = HW'(H_VISIBLE);
    localparam logic [HW-1:0] C_HS_BEG   = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] C_HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] C_V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] C_V_VIS    = VW'(V_VISIBLE);
    localparam logic [VW-1:0] C_VS_BEG   = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] C_VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          h_last;
    logic          v_last;

    assign h_last = (h_q == C_H_LAST);
    assign v_last = (v_q == C_V_LAST);

    // Next scan position: h wraps at end of line, v steps on each h wrap
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pix_ce) begin
            if (h_last) begin
                h_d = '0;
                v_d = v_last ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Scan position registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_cnt_o   = h_q;
    assign v_cnt_o   = v_q;
    assign h_wrap_o  = pix_ce & h_last;
    assign v_wrap_o  = pix_ce & h_last & v_last;
    assign h_act_o   = (h_q < C_H_VIS);
    assign v_act_o   = (v_q < C_V_VIS);
    assign hsync_n_o = !((h_q >= C_HS_BEG) && (h_q < C_HS_END));
    assign vsync_n_o = !((v_q >= C_VS_BEG) && (v_q < C_VS_END));

endmodule

`default_nettype wire

// File: rtl/vga_grid_reader.sv
// ============================================================================
//  Module      : vga_grid_reader
//  Description : Scans a register bank cell-by-cell under VGA timing and
//                renders the cells as a grid on RGB111 with aligned syncs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_grid_reader #(
    parameter int BIT_ADDR   = 4,
    parameter int BIT_DATO   = 3,
    parameter int H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
    parameter int H_FRONT    = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int H_BACK     = vga_timing_pkg::H_BACK,
    parameter int V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
    parameter int V_FRONT    = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int V_BACK     = vga_timing_pkg::V_BACK,
    parameter int CELL_W     = 160,
    parameter int CELL_H     = 120,
    parameter int GRID_LINES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pix_ce,
    input  logic [BIT_DATO-1:0] datInR,
    output logic [BIT_ADDR-1:0] addrR,
    output logic                hsync,
    output logic                vsync,
    output logic [2:0]          rgb,
    output logic                frame_start
);

    import vga_timing_pkg::*;

    localparam int CB = BIT_ADDR / 2;
    localparam int HW = cnt_width(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
    localparam int VW = cnt_width(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
    localparam int XW = cnt_width(CELL_W);
    localparam int YW = cnt_width(CELL_H);

    localparam logic [XW-1:0] C_X_LAST = XW'(CELL_W - 1);
    localparam logic [YW-1:0] C_Y_LAST = YW'(CELL_H - 1);
    localparam logic          C_GRID   = (GRID_LINES != 0);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap;
    logic          v_wrap;
    logic          h_act;
    logic          v_act;
    logic          hsync_n;
    logic          vsync_n;

    vga_timing_gen #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK),
        .HW        (HW),
        .VW        (VW)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .pix_ce    (pix_ce),
        .h_cnt_o   (h_cnt),
        .v_cnt_o   (v_cnt),
        .h_wrap_o  (h_wrap),
        .v_wrap_o  (v_wrap),
        .h_act_o   (h_act),
        .v_act_o   (v_act),
        .hsync_n_o (hsync_n),
        .vsync_n_o (vsync_n)
    );

    // Cell position tracked incrementally, in step with h_cnt/v_cnt
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [CB-1:0] col_q, col_d;
    logic [CB-1:0] row_q, row_d;

    // S1 (address + pixel attributes) and S2 (pin) registers
    s1_t                 s1_q, s1_d;
    logic [BIT_ADDR-1:0] addr_q, addr_d;
    logic [2:0]          rgb_q, rgb_d;
    logic                hsync_q, hsync_d;
    logic                vsync_q, vsync_d;
    logic                fs_q, fs_d;

    // Cell sub-counters: x/col step across visible pixels, y/row across visible lines
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        col_d = col_q;
        row_d = row_q;
        if (h_wrap) begin
            x_d   = '0;
            col_d = '0;
            if (v_wrap) begin
                y_d   = '0;
                row_d = '0;
            end else if (v_act) begin
                if (y_q == C_Y_LAST) begin
                    y_d   = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end
        end else if (pix_ce && h_act) begin
            if (x_q == C_X_LAST) begin
                x_d   = '0;
                col_d = col_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // S1: issue the bank read for visible pixels; blanking keeps the last address
    always_comb begin
        s1_d   = s1_q;
        addr_d = addr_q;
        if (pix_ce) begin
            s1_d.active    = h_act & v_act;
            s1_d.cell_edge = (x_q == '0) || (y_q == '0);
            s1_d.hsync_n   = hsync_n;
            s1_d.vsync_n   = vsync_n;
            s1_d.first     = (h_cnt == '0) && (v_cnt == '0);
            if (h_act && v_act) begin
                addr_d = {row_q, col_q};
            end
        end
    end

    // S2: colour from the bank datum returned for addrR; frame_start lasts one clk
    always_comb begin
        rgb_d   = rgb_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        fs_d    = 1'b0;
        if (pix_ce) begin
            if (!s1_q.active) begin
                rgb_d = RGB_BLACK;
            end else if (C_GRID && s1_q.cell_edge) begin
                rgb_d = RGB_WHITE;
            end else begin
                rgb_d = 3'(datInR);
            end
            hsync_d = s1_q.hsync_n;
            vsync_d = s1_q.vsync_n;
            fs_d    = s1_q.first;
        end
    end

    // State registers for the cell counters and both pipeline stages
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            row_q   <= '0;
            s1_q    <= S1_IDLE;
            addr_q  <= '0;
            rgb_q   <= RGB_BLACK;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            row_q   <= row_d;
            s1_q    <= s1_d;
            addr_q  <= addr_d;
            rgb_q   <= rgb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            fs_q    <= fs_d;
        end
    end

    assign addrR       = addr_q;
    assign rgb         = rgb_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fs_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_grid_reader.sv
// ============================================================================
//  Module      : tb_vga_grid_reader
//  Description : Self-checking bench for vga_grid_reader: full-size, mid-size
//                (grid on/off) and tiny instances against a coordinate model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_grid_reader;

    typedef struct {
        int hv, hf, hs, hb;
        int vv, vf, vs, vb;
        int cw, ch;
        int grid;
        int ba;
    } cfg_t;

    typedef struct {
        int         addr;
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
        logic       fs;
    } exp_t;

    typedef struct {
        int         f, h, v;
        int         addr;
        logic [2:0] rgb_m;
        logic [2:0] rgb_g;
        logic       hs;
        logic       vs;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic pix_ce;

    always #5 clk = ~clk;

    logic [3:0] addr_a, addr_m, addr_g;
    logic [1:0] addr_s;
    logic [2:0] dat_a, dat_m, dat_g, dat_s;
    logic [2:0] rgb_a, rgb_m, rgb_g, rgb_s;
    logic       hs_a, hs_m, hs_g, hs_s;
    logic       vs_a, vs_m, vs_g, vs_s;
    logic       fs_a, fs_m, fs_g, fs_s;

    // Bank model: cell k holds k[2:0], returned combinationally
    assign dat_a = addr_a[2:0];
    assign dat_m = addr_m[2:0];
    assign dat_g = addr_g[2:0];
    assign dat_s = {1'b0, addr_s};

    vga_grid_reader #(.GRID_LINES(1)) dut_a (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .datInR(dat_a), .addrR(addr_a),
        .hsync(hs_a), .vsync(vs_a), .rgb(rgb_a), .frame_start(fs_a));

    vga_grid_reader #(.H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
                      .V_VISIBLE(48), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
                      .CELL_W(16), .CELL_H(12), .GRID_LINES(0)) dut_m (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .datInR(dat_m), .addrR(addr_m),
        .hsync(hs_m), .vsync(vs_m), .rgb(rgb_m), .frame_start(fs_m));

    vga_grid_reader #(.H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
                      .V_VISIBLE(48), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
                      .CELL_W(16), .CELL_H(12), .GRID_LINES(1)) dut_g (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .datInR(dat_g), .addrR(addr_g),
        .hsync(hs_g), .vsync(vs_g), .rgb(rgb_g), .frame_start(fs_g));

    vga_grid_reader #(.BIT_ADDR(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
                      .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                      .CELL_W(4), .CELL_H(2), .GRID_LINES(1)) dut_s (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .datInR(dat_s), .addrR(addr_s),
        .hsync(hs_s), .vsync(vs_s), .rgb(rgb_s), .frame_start(fs_s));

    cfg_t ca, cm, cg, cs;
    int   edges;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic fs_edge_a;

    bit   track_en;
    int   hs_low, hs_first, vl_cnt, vl_first, fs_m_n;
    int   fs_m_e[2];

    vec_t tbl[11];

    // Expected outputs after 'e' pix_ce edges since reset release, from scan coordinates
    function automatic exp_t model(input cfg_t c, input int e);
        exp_t x;
        int ht, vt, q, h, v, ncol, a;
        ht   = c.hv + c.hf + c.hs + c.hb;
        vt   = c.vv + c.vf + c.vs + c.vb;
        ncol = 1 << (c.ba / 2);
        x.addr = 0; x.rgb = 3'b000; x.hs = 1'b1; x.vs = 1'b1; x.fs = 1'b0;
        if (e >= 1) begin
            q = (e - 1) % (ht * vt);
            h = q % ht;
            v = q / ht;
            if (v >= c.vv) begin
                h = c.hv - 1;
                v = c.vv - 1;
            end else if (h >= c.hv) begin
                h = c.hv - 1;
            end
            x.addr = (v / c.ch) * ncol + h / c.cw;
        end
        if (e >= 2) begin
            q = (e - 2) % (ht * vt);
            h = q % ht;
            v = q / ht;
            if (h < c.hv && v < c.vv) begin
                a = (v / c.ch) * ncol + h / c.cw;
                if (c.grid != 0 && (h % c.cw == 0 || v % c.ch == 0)) x.rgb = 3'b111;
                else x.rgb = 3'(a % 8);
            end
            x.hs = !(h >= c.hv + c.hf && h < c.hv + c.hf + c.hs);
            x.vs = !(v >= c.vv + c.vf && v < c.vv + c.vf + c.vs);
            x.fs = (q == 0);
        end
        return x;
    endfunction

    task automatic chk(input string nm, input cfg_t c, input int a, input logic [2:0] r,
                       input logic h, input logic v, input logic f, input bit hold);
        exp_t x;
        x = model(c, edges);
        if (hold) x.fs = 1'b0;
        n_cmp++;
        if (a != x.addr || r !== x.rgb || h !== x.hs || v !== x.vs || f !== x.fs) begin
            n_bad++;
            $display("FAIL %s e=%0d: got addr=%0h rgb=%b hs=%b vs=%b fs=%b, want addr=%0h rgb=%b hs=%b vs=%b fs=%b",
                     nm, edges, a, r, h, v, f, x.addr, x.rgb, x.hs, x.vs, x.fs);
        end
    endtask

    task automatic check_all(input bit hold);
        chk("dut_a", ca, int'(addr_a), rgb_a, hs_a, vs_a, fs_a, hold);
        chk("dut_m", cm, int'(addr_m), rgb_m, hs_m, vs_m, fs_m, hold);
        chk("dut_g", cg, int'(addr_g), rgb_g, hs_g, vs_g, fs_g, hold);
        chk("dut_s", cs, int'(addr_s), rgb_s, hs_s, vs_s, fs_s, hold);
    endtask

    task automatic cmp_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic track();
        int r;
        if (track_en && edges >= 2) begin
            r = edges - 2;
            if (r < 800 && hs_a == 1'b0) begin
                if (hs_first < 0) hs_first = r;
                hs_low++;
            end
            if (r < 4400 && r % 80 == 0 && vs_m == 1'b0) begin
                if (vl_first < 0) vl_first = r / 80;
                vl_cnt++;
            end
            if (fs_m == 1'b1 && fs_m_n < 2) begin
                fs_m_e[fs_m_n] = edges;
                fs_m_n++;
            end
        end
    endtask

    // One pixel: pix_ce high for one clk, then low for one clk
    task automatic step();
        @(negedge clk) pix_ce = 1'b1;
        @(posedge clk);
        #1;
        edges++;
        fs_edge_a = fs_a;
        check_all(1'b0);
        track();
        @(negedge clk) pix_ce = 1'b0;
        @(posedge clk);
        #1;
        check_all(1'b1);
    endtask

    task automatic go_to(input int tgt);
        while (edges < tgt) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, edges=%0d", edges);
        $fatal(1, "watchdog");
    end

    initial begin
        ca = '{640, 16, 96, 48, 480, 10, 2, 33, 160, 120, 1, 4};
        cm = '{64, 4, 8, 4, 48, 2, 2, 3, 16, 12, 0, 4};
        cg = '{64, 4, 8, 4, 48, 2, 2, 3, 16, 12, 1, 4};
        cs = '{8, 2, 2, 2, 4, 1, 1, 1, 4, 2, 1, 2};

        //             f  h   v  addr  rgb_m   rgb_g   hs    vs
        tbl[0]  = '{0,  0,  0, 4'h0, 3'b000, 3'b111, 1'b1, 1'b1};
        tbl[1]  = '{0, 16,  5, 4'h1, 3'b001, 3'b111, 1'b1, 1'b1};
        tbl[2]  = '{0, 70,  5, 4'h3, 3'b000, 3'b000, 1'b0, 1'b1};
        tbl[3]  = '{0,  5, 12, 4'h4, 3'b100, 3'b111, 1'b1, 1'b1};
        tbl[4]  = '{0, 17, 13, 4'h5, 3'b101, 3'b101, 1'b1, 1'b1};
        tbl[5]  = '{0, 40, 30, 4'hA, 3'b010, 3'b010, 1'b1, 1'b1};
        tbl[6]  = '{0, 63, 47, 4'hF, 3'b111, 3'b111, 1'b1, 1'b1};
        tbl[7]  = '{0, 10, 50, 4'hF, 3'b000, 3'b000, 1'b1, 1'b0};
        tbl[8]  = '{0, 10, 52, 4'hF, 3'b000, 3'b000, 1'b1, 1'b1};
        tbl[9]  = '{0, 79, 54, 4'hF, 3'b000, 3'b000, 1'b1, 1'b1};
        tbl[10] = '{1,  0,  0, 4'h0, 3'b000, 3'b111, 1'b1, 1'b1};

        hs_low = 0; hs_first = -1; vl_cnt = 0; vl_first = -1; fs_m_n = 0;
        fs_m_e[0] = 0; fs_m_e[1] = 0;
        track_en = 1'b1;
        edges = 0;
        rst = 1'b0;
        pix_ce = 1'b0;

        // Reset held with pix_ce toggling: reset values everywhere
        repeat (6) begin
            @(negedge clk) pix_ce = ~pix_ce;
            @(posedge clk);
            #1;
            check_all(1'b0);
        end
        @(negedge clk) begin
            pix_ce = 1'b0;
            rst = 1'b1;
        end

        // Directed pixels on the mid-size instances, in scan order
        for (int i = 0; i < 11; i++) begin
            int p;
            p = tbl[i].f * 4400 + tbl[i].v * 80 + tbl[i].h;
            if (edges > p + 1) begin
                cmp_int($sformatf("tbl%0d_order", i), edges, p + 1);
            end else begin
                go_to(p + 1);
                cmp_int($sformatf("tbl%0d_addr_m", i), int'(addr_m), tbl[i].addr);
                cmp_int($sformatf("tbl%0d_addr_g", i), int'(addr_g), tbl[i].addr);
                go_to(p + 2);
                cmp_int($sformatf("tbl%0d_rgb_m", i), int'(rgb_m), int'(tbl[i].rgb_m));
                cmp_int($sformatf("tbl%0d_rgb_g", i), int'(rgb_g), int'(tbl[i].rgb_g));
                cmp_int($sformatf("tbl%0d_hsync", i), int'(hs_m), int'(tbl[i].hs));
                cmp_int($sformatf("tbl%0d_vsync", i), int'(vs_m), int'(tbl[i].vs));
            end
        end

        // Line/frame timing observed during the first frame
        track_en = 1'b0;
        cmp_int("hsync_low_len", hs_low, 96);
        cmp_int("hsync_low_start", hs_first, 656);
        cmp_int("vsync_low_lines", vl_cnt, 2);
        cmp_int("vsync_first_line", vl_first, 50);
        cmp_int("frame_start_count", fs_m_n, 2);
        cmp_int("frame_start_first", fs_m_e[0], 2);
        cmp_int("frame_period", fs_m_e[1] - fs_m_e[0], 4400);

        // pix_ce held low for 10 clk mid-line, then resume
        go_to(4430);
        repeat (10) begin
            @(posedge clk);
            #1;
            check_all(1'b1);
        end
        go_to(4470);

        // Asynchronous reset mid-frame with pix_ce active
        @(negedge clk) pix_ce = 1'b1;
        #2;
        rst = 1'b0;
        edges = 0;
        #1;
        check_all(1'b0);
        cmp_int("midrst_rgb", int'(rgb_a), 0);
        cmp_int("midrst_hsync", int'(hs_a), 1);
        repeat (4) begin
            @(negedge clk) pix_ce = ~pix_ce;
            @(posedge clk);
            #1;
            check_all(1'b0);
        end
        @(negedge clk) begin
            pix_ce = 1'b0;
            rst = 1'b1;
        end

        // frame_start two pix_ce after release
        step();
        cmp_int("restart_fs_e1", int'(fs_edge_a), 0);
        step();
        cmp_int("restart_fs_e2", int'(fs_edge_a), 1);
        go_to(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
